dmem_line_ctrl: RTL and testbench
=================================

Name: dmem_line_ctrl

Overview:
- Line-granular backing data memory with a fixed-latency request/acknowledge handshake.
- Sits directly downstream of the data cache and services its 256-bit line fills (read) and dirty-line write-backs (write).
- Presents a multi-cycle miss penalty so the cache stall path is exercised realistically.
- Holds the memory array and a small request FSM with a latency counter.

Parameters:
LINE_W, 256, line width in bits (one cache line per access)
IDX_W, 9, line-index width; depth = 2^IDX_W lines (512 lines = 16 KB)
LATENCY, 10, cycles from request acceptance to ack_o; legal range 1..255

Ports:
clk_i  input  1  system clock; all state changes on rising edge
rst_i  input  1  reset; synchronous, active-high
addr_i  input  32  byte address; line index = addr_i[5+IDX_W-1:5]; addr_i[4:0] and upper bits ignored
data_i  input  LINE_W  write line data
enable_i  input  1  request valid
write_i  input  1  1 = write line, 0 = read line; meaningful only with enable_i
ack_o  output  1  one-cycle completion pulse, registered
data_o  output  LINE_W  read line data, registered; valid while ack_o=1 for reads

Behaviour:
- Reset (rst_i=1 at a rising edge):
  - state<=IDLE, counter<=0, ack_o<=0, data_o<=0.
  - Array contents are not cleared.
  - Reset mid-request aborts it: no ack, and a pending write is not committed.
- States: IDLE, BUSY, ACK.
- IDLE:
  - If enable_i=1 at an edge, the request is accepted.
  - addr index, data_i and write_i are latched; counter<=0; go to BUSY.
  - Otherwise stay in IDLE.
- BUSY:
  - counter increments each edge.
  - At the edge where counter==LATENCY-1, go to ACK:
    - write: array[idx]<=latched data;
    - read: data_o<=array[idx].
  - With LATENCY=1, ACK is reached on the first BUSY edge.
- ACK:
  - ack_o=1 for exactly this one cycle.
  - Next edge returns to IDLE unconditionally.
- Latency: ack_o is high in the cycle beginning LATENCY edges after the accepting edge.
- Inputs during BUSY/ACK are ignored:
  - changes to addr_i, data_i or write_i do not affect the in-flight request;
  - dropping enable_i does not cancel it (ack still pulses).
- enable_i still high during the ACK cycle is not a new request. The next request can only be accepted on the edge after ACK, i.e. from IDLE.
  - Back-to-back: enable_i held high through ACK and IDLE gives a new acceptance on the first IDLE edge.
  - Minimum request spacing is LATENCY+2 cycles.
- data_o is updated only by read completions. It holds its value through writes and idle periods.
- Read-after-write to the same line returns the newly written data. The write is committed no later than the edge entering ACK.
- Index wrap: addresses differing only above bit 5+IDX_W-1 alias to the same line.
- write_i with enable_i=0 has no effect.
- The array is exposed as a plain register array named memory, so benches can preload it hierarchically.

Test Plan:
- Reset/idle: assert rst_i 2 cycles, then enable_i=0 for 20 cycles -> ack_o=0 and data_o=0 throughout.
- Read latency (LATENCY=10):
  - stimulus: preload memory[3]=256'hA5..A5; enable_i=1, write_i=0, addr_i=32'h0000_0060;
  - required: ack_o high exactly in cycle 10 after the accepting edge, data_o=A5..A5 during it, ack_o low the next cycle.
- Write then read:
  - stimulus: write line 256'h0123..CDEF to addr 32'h0000_0400 (index 32), wait ack; read the same address;
  - required: data_o=0123..CDEF; data_o unchanged by the write's own ack.
- Input instability:
  - stimulus: accept read of index 5, then during BUSY change addr_i to index 6, set write_i=1, and drop enable_i;
  - required: ack still pulses at cycle 10, data_o=memory[5], memory[6] unmodified.
- Back-to-back and aliasing:
  - stimulus: enable_i held high continuously with addr_i=32'h0000_4020 (aliases index 1 when IDX_W=9);
  - required: acks at cycles 10 and 22 relative to first accept (spacing LATENCY+2), data from memory[1].
- Reset mid-write:
  - stimulus: accept write to index 7, assert rst_i at BUSY cycle 4;
  - required: no ack_o, and memory[7] retains its prior value.

Source files
------------

// File: rtl/dmem_line_ctrl.sv
// Line-granular backing data memory for the data cache.
// Each read or write takes a fixed number of cycles and ends with a one-cycle ack pulse.
module dmem_line_ctrl #(
    parameter int LINE_W  = 256,
    parameter int IDX_W   = 9,
    parameter int LATENCY = 10
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic [31:0]       addr_i,
    input  logic [LINE_W-1:0] data_i,
    input  logic              enable_i,
    input  logic              write_i,
    output logic              ack_o,
    output logic [LINE_W-1:0] data_o
);

    typedef enum logic [1:0] {IDLE, BUSY, ACK} state_t;

    localparam logic [7:0] LAST_COUNT = 8'(LATENCY - 1);

    state_t            state;
    logic [7:0]        counter;
    logic [IDX_W-1:0]  idx;
    logic [LINE_W-1:0] wdata;
    logic              wr;
    logic              done;

    logic [LINE_W-1:0] memory [0:(1 << IDX_W) - 1];

    // Only the line index matters; byte offset and high bits alias freely.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{addr_i[31:5+IDX_W], addr_i[4:0]};

    assign done = (state == BUSY) && (counter == LAST_COUNT);

    // Request FSM: latch the request in IDLE so later input changes cannot disturb it.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state   <= IDLE;
            counter <= '0;
            ack_o   <= 1'b0;
            data_o  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    ack_o <= 1'b0;
                    if (enable_i) begin
                        idx     <= addr_i[5+IDX_W-1:5];
                        wdata   <= data_i;
                        wr      <= write_i;
                        counter <= '0;
                        state   <= BUSY;
                    end
                end
                BUSY: begin
                    counter <= counter + 8'd1;
                    if (counter == LAST_COUNT) begin
                        state <= ACK;
                        ack_o <= 1'b1;
                        if (!wr) begin
                            data_o <= memory[idx];
                        end
                    end
                end
                ACK: begin
                    ack_o <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    ack_o <= 1'b0;
                    state <= IDLE;
                end
            endcase
        end
    end

    // Writes commit on the edge entering ACK; a reset on that edge drops the write.
    always_ff @(posedge clk_i) begin
        if (!rst_i && done && wr) begin
            memory[idx] <= wdata;
        end
    end

endmodule

// File: tb/tb_dmem_line_ctrl.sv
// Self-checking bench for dmem_line_ctrl: a scoreboard queue holds the expected ack cycle
// and data for every request, and a negedge monitor matches them against ack_o/data_o.
module tb_dmem_line_ctrl;

    localparam int LINE_W  = 256;
    localparam int IDX_W   = 9;
    localparam int LATENCY = 10;

    typedef struct {
        logic              is_read;
        logic [IDX_W-1:0]  idx;
        logic [LINE_W-1:0] wdata;
        logic [LINE_W-1:0] exp_data;
        int                ack_cycle;
    } item_t;

    logic              clk_i;
    logic              rst_i;
    logic [31:0]       addr_i;
    logic [LINE_W-1:0] data_i;
    logic              enable_i;
    logic              write_i;
    logic              ack_o;
    logic [LINE_W-1:0] data_o;

    int                checks   = 0;
    int                failures = 0;
    int                cyc      = 0;
    item_t             sb[$];
    item_t             it;
    logic [LINE_W-1:0] model_mem [0:(1 << IDX_W) - 1];
    logic [LINE_W-1:0] last_read;
    int                acc;

    dmem_line_ctrl #(
        .LINE_W (LINE_W),
        .IDX_W  (IDX_W),
        .LATENCY(LATENCY)
    ) dut (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .addr_i  (addr_i),
        .data_i  (data_i),
        .enable_i(enable_i),
        .write_i (write_i),
        .ack_o   (ack_o),
        .data_o  (data_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // cyc holds the number of rising edges seen so far.
    always @(posedge clk_i) cyc <= cyc + 1;

    task automatic checkOutput(input string tag, input logic [LINE_W-1:0] got,
                               input logic [LINE_W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("[TB] FAIL %s: got=%h expected=%h (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic pushExpected(input logic is_read, input logic [IDX_W-1:0] idx,
                                input logic [LINE_W-1:0] d, input int ack_cycle);
        item_t e;
        e.is_read   = is_read;
        e.idx       = idx;
        e.wdata     = d;
        e.ack_cycle = ack_cycle;
        if (is_read) begin
            e.exp_data = model_mem[idx];
            last_read  = model_mem[idx];
        end else begin
            e.exp_data = last_read;
        end
        sb.push_back(e);
    endtask

    // Drives a request while the DUT is idle; it is accepted on the following edge.
    task automatic applyStimulus(input logic wr, input logic [31:0] addr,
                                 input logic [LINE_W-1:0] d, output int accept_edge);
        @(posedge clk_i);
        #1;
        enable_i    = 1'b1;
        write_i     = wr;
        addr_i      = addr;
        data_i      = d;
        accept_edge = cyc + 1;
        pushExpected(!wr, addr[5+IDX_W-1:5], d, accept_edge + LATENCY);
    endtask

    task automatic dropEnableAfterAccept();
        @(posedge clk_i);
        #1;
        enable_i = 1'b0;
    endtask

    task automatic waitIdle();
        for (int i = 0; i < 100 && sb.size() != 0; i++) @(posedge clk_i);
        checkOutput("queue_drained", LINE_W'(sb.size()), '0);
        sb.delete();
    endtask

    // Monitor: every ack must match the oldest expected request, on its exact cycle.
    always @(negedge clk_i) begin
        if (ack_o === 1'b1) begin
            if (sb.size() == 0) begin
                checkOutput("spurious_ack", LINE_W'(ack_o), '0);
            end else begin
                it = sb.pop_front();
                checkOutput("ack_cycle", LINE_W'(cyc), LINE_W'(it.ack_cycle));
                checkOutput(it.is_read ? "read_data" : "data_hold", data_o, it.exp_data);
                if (!it.is_read) model_mem[it.idx] = it.wdata;
            end
        end else if (sb.size() != 0 && cyc >= sb[0].ack_cycle) begin
            checkOutput("missed_ack", LINE_W'(ack_o), LINE_W'(1));
            void'(sb.pop_front());
        end
    end

    initial begin
        rst_i     = 1'b1;
        enable_i  = 1'b0;
        write_i   = 1'b0;
        addr_i    = '0;
        data_i    = '0;
        last_read = '0;

        dut.memory[1] <= {8{32'h1111_0001}};
        dut.memory[3] <= {32{8'hA5}};
        dut.memory[5] <= {8{32'h5555_0005}};
        dut.memory[6] <= {8{32'h6666_0006}};
        dut.memory[7] <= {8{32'h7777_0007}};
        model_mem[1] = {8{32'h1111_0001}};
        model_mem[3] = {32{8'hA5}};
        model_mem[5] = {8{32'h5555_0005}};
        model_mem[6] = {8{32'h6666_0006}};
        model_mem[7] = {8{32'h7777_0007}};

        repeat (2) @(posedge clk_i);
        #1;
        rst_i = 1'b0;

        for (int i = 0; i < 20; i++) begin
            @(negedge clk_i);
            checkOutput("idle_ack", LINE_W'(ack_o), '0);
            checkOutput("idle_data", data_o, '0);
        end

        // Plain read of line 3.
        applyStimulus(1'b0, 32'h0000_0060, '0, acc);
        dropEnableAfterAccept();
        waitIdle();

        // Write line 32, then read it back.
        applyStimulus(1'b1, 32'h0000_0400, {4{64'h0123_4567_89AB_CDEF}}, acc);
        dropEnableAfterAccept();
        waitIdle();
        applyStimulus(1'b0, 32'h0000_0400, '0, acc);
        dropEnableAfterAccept();
        waitIdle();

        // Inputs wiggled during BUSY must not disturb the in-flight read of line 5.
        applyStimulus(1'b0, 32'h0000_00A0, '0, acc);
        @(posedge clk_i);
        #1;
        addr_i   = 32'h0000_00C0;
        write_i  = 1'b1;
        enable_i = 1'b0;
        data_i   = {8{32'hBAD0_BAD0}};
        waitIdle();
        checkOutput("mem6_untouched", dut.memory[6], model_mem[6]);
        write_i = 1'b0;

        // Enable held high: two aliased reads of line 1 spaced LATENCY+2 apart.
        applyStimulus(1'b0, 32'h0000_4020, '0, acc);
        pushExpected(1'b1, 9'd1, '0, acc + 2 * LATENCY + 2);
        repeat (13) @(posedge clk_i);
        #1;
        enable_i = 1'b0;
        waitIdle();

        // Reset at BUSY cycle 4 aborts the write to line 7.
        applyStimulus(1'b1, 32'h0000_00E0, {8{32'hDEAD_BEEF}}, acc);
        dropEnableAfterAccept();
        repeat (3) @(posedge clk_i);
        #1;
        rst_i = 1'b1;
        sb.delete();
        last_read = '0;
        @(posedge clk_i);
        #1;
        rst_i = 1'b0;
        repeat (20) @(negedge clk_i);
        checkOutput("mem7_kept", dut.memory[7], model_mem[7]);
        checkOutput("data_after_reset", data_o, '0);

        applyStimulus(1'b0, 32'h0000_00E0, '0, acc);
        dropEnableAfterAccept();
        waitIdle();

        repeat (3) @(posedge clk_i);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
